// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// Waits on the memory ready handshake and on the optional mul/div unit.
// Halts on illegal opcodes and counts retired instructions.
// Datapath strobes are decoded from the current state, the registered instruction
// class and the live handshake inputs. They are all zero in IDLE, which reset forces
// asynchronously.
module multicycle_control #(
  parameter bit          MEM_WAIT     = 1'b1,
  parameter bit          HAS_MULDIV   = 1'b1,
  parameter bit          ILLEGAL_HALT = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic             Funct7_0,
  input  logic             MemReady,
  input  logic             BranchTaken,
  input  logic             MulDivDone,
  output logic             InstrFetch,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcA,
  output logic             ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MulDivStart,
  output logic             RegWrite,
  output logic [1:0]       WBSel,
  output logic             Halt,
  output logic [CNT_W-1:0] InstRet,
  output logic [2:0]       State
);

  // The encoding doubles as the debug State output.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExec    = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StMulWait = 3'd6,
    StHalt    = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsNone  = 4'd0,
    ClsR     = 4'd1,
    ClsI     = 4'd2,
    ClsLoad  = 4'd3,
    ClsStore = 4'd4,
    ClsBr    = 4'd5,
    ClsJal   = 4'd6,
    ClsJalr  = 4'd7,
    ClsLui   = 4'd8,
    ClsAuipc = 4'd9
  } cls_e;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  state_e           r_state;
  cls_e             r_cls;
  logic             r_mul;
  logic [CNT_W-1:0] r_instret;

  state_e w_state_d;
  cls_e   w_cls_d;
  cls_e   w_dec_cls;
  logic   w_mul_d;
  logic   w_retire;
  logic   w_mem_ready;

  // With single-cycle memory every access completes immediately.
  assign w_mem_ready = MEM_WAIT ? MemReady : 1'b1;

  // Classify the opcode held in the instruction register.
  always_comb begin
    w_dec_cls = ClsNone;
    unique case (Opcode)
      OpR:     w_dec_cls = ClsR;
      OpI:     w_dec_cls = ClsI;
      OpLoad:  w_dec_cls = ClsLoad;
      OpStore: w_dec_cls = ClsStore;
      OpBr:    w_dec_cls = ClsBr;
      OpJal:   w_dec_cls = ClsJal;
      OpJalr:  w_dec_cls = ClsJalr;
      OpLui:   w_dec_cls = ClsLui;
      OpAuipc: w_dec_cls = ClsAuipc;
      default: w_dec_cls = ClsNone;
    endcase
  end

  // Next state, class capture and retire pulse.
  always_comb begin
    w_state_d = r_state;
    w_cls_d   = r_cls;
    w_mul_d   = r_mul;
    w_retire  = 1'b0;
    unique case (r_state)
      StIdle: w_state_d = StFetch;
      StFetch: begin
        if (w_mem_ready) w_state_d = StDecode;
      end
      StDecode: begin
        w_cls_d = w_dec_cls;
        w_mul_d = HAS_MULDIV & Funct7_0;
        if (w_dec_cls == ClsNone) begin
          // Unknown opcodes either stop the core or are skipped without counting.
          w_state_d = ILLEGAL_HALT ? StHalt : StFetch;
        end else begin
          w_state_d = StExec;
        end
      end
      StExec: begin
        unique case (r_cls)
          ClsR:            w_state_d = r_mul ? StMulWait : StWb;
          ClsI, ClsAuipc:  w_state_d = StWb;
          ClsLoad, ClsStore: w_state_d = StMem;
          ClsBr, ClsJal, ClsJalr, ClsLui: begin
            w_state_d = StFetch;
            w_retire  = 1'b1;
          end
          default:         w_state_d = StFetch;
        endcase
      end
      StMem: begin
        if (w_mem_ready) begin
          if (r_cls == ClsLoad) begin
            w_state_d = StWb;
          end else begin
            w_state_d = StFetch;
            w_retire  = 1'b1;
          end
        end
      end
      StMulWait: begin
        if (MulDivDone) w_state_d = StWb;
      end
      StWb: begin
        w_state_d = StFetch;
        w_retire  = 1'b1;
      end
      StHalt: w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  // State, class and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cls     <= ClsNone;
      r_mul     <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_d;
      r_cls   <= w_cls_d;
      r_mul   <= w_mul_d;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Datapath strobes for the current state and class.
  always_comb begin
    InstrFetch  = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 1'b0;
    ALUOp       = 2'b00;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MulDivStart = 1'b0;
    RegWrite    = 1'b0;
    WBSel       = 2'b00;
    Halt        = 1'b0;
    unique case (r_state)
      StFetch: begin
        InstrFetch = 1'b1;
        MemRead    = 1'b1;
        IRWrite    = w_mem_ready;
        PCWrite    = w_mem_ready;
      end
      StExec: begin
        unique case (r_cls)
          ClsR: begin
            ALUOp       = 2'b10;
            MulDivStart = r_mul;
          end
          ClsI: begin
            ALUOp   = 2'b11;
            ALUSrcB = 1'b1;
          end
          ClsLoad, ClsStore: ALUSrcB = 1'b1;
          ClsBr: begin
            ALUOp   = 2'b01;
            PCWrite = BranchTaken;
            PCSrc   = BranchTaken ? 2'b01 : 2'b00;
          end
          ClsJal: begin
            RegWrite = 1'b1;
            WBSel    = 2'b10;
            PCWrite  = 1'b1;
            PCSrc    = 2'b01;
          end
          ClsJalr: begin
            ALUSrcB  = 1'b1;
            RegWrite = 1'b1;
            WBSel    = 2'b10;
            PCWrite  = 1'b1;
            PCSrc    = 2'b10;
          end
          ClsLui: begin
            RegWrite = 1'b1;
            WBSel    = 2'b11;
          end
          ClsAuipc: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        MemRead  = (r_cls == ClsLoad);
        MemWrite = (r_cls == ClsStore);
      end
      StWb: begin
        RegWrite = 1'b1;
        WBSel    = (r_cls == ClsLoad) ? 2'b01 : 2'b00;
      end
      StHalt: Halt = 1'b1;
      default: ;
    endcase
  end

  assign InstRet = r_instret;
  assign State   = r_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- FSM-based main control for the multicycle RV32I core. Successor to the single-cycle combinational opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and on an optional multi-cycle mul/div unit.
- Halts on illegal opcodes and counts retired instructions.
- Sits between the instruction register (Opcode, Funct7_0), memory (MemReady), ALU (BranchTaken) and the multicycle datapath muxes and enables.

Parameters:
- MEM_WAIT, 1, 1: FETCH/MEM hold until MemReady. 0: memory is single-cycle and MemReady is ignored (treated as 1).
- HAS_MULDIV, 1, 1: R-type with Funct7_0=1 goes through MULWAIT. 0: Funct7_0 is ignored.
- ILLEGAL_HALT, 1, 1: unknown opcode enters HALT. 0: unknown opcode is a NOP and is not counted.
- CNT_W, 32, width of the InstRet counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  7  IR[6:0]; valid from DECODE until the next IRWrite.
- Funct7_0  in  1  IR[25] (M-extension select).
- MemReady  in  1  memory access completes this cycle.
- BranchTaken  in  1  ALU compare result; valid in EXEC.
- MulDivDone  in  1  mul/div result valid.
- InstrFetch  out  1  memory address = PC.
- IRWrite  out  1  latch IR.
- PCWrite  out  1  update PC.
- PCSrc  out  2  00 PC+4, 01 OldPC+imm, 10 ALU result with LSB cleared.
- ALUSrcA  out  2  00 rs1, 01 OldPC.
- ALUSrcB  out  1  0 rs2, 1 imm.
- ALUOp  out  2  00 add, 01 sub, 10 R-type, 11 I-type.
- MemRead  out  1
- MemWrite  out  1
- MulDivStart  out  1  one-cycle pulse.
- RegWrite  out  1
- WBSel  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
- Halt  out  1  sticky.
- InstRet  out  CNT_W  retired-instruction count.
- State  out  3  debug: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 MULWAIT=6 HALT=7.

Behaviour:
- Outputs are decoded from the state, the registered class and the inputs. Any output not asserted in a state is 0.
- Reset (async, may occur mid-instruction):
  - State=IDLE, InstRet=0, Halt=0, class register cleared.
  - All outputs 0 while rst_n is low and during IDLE.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH:
  - InstrFetch=1, MemRead=1.
  - On MemReady: IRWrite=1, PCWrite=1, PCSrc=00, -> DECODE.
  - Otherwise hold with all strobes stable.
- DECODE:
  - Register the class from Opcode: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Unknown opcode: -> HALT if ILLEGAL_HALT, else -> FETCH with no count.
  - Valid opcode: -> EXEC. No strobes asserted.
- EXEC, per class:
  - R: ALUOp=10, ALUSrcB=0. If HAS_MULDIV && Funct7_0: MulDivStart=1, -> MULWAIT; else -> WB.
  - I: ALUOp=11, ALUSrcB=1, -> WB.
  - LOAD/STORE: ALUOp=00, ALUSrcB=1, -> MEM.
  - BR: ALUOp=01, ALUSrcB=0. If BranchTaken: PCWrite=1, PCSrc=01. Retire, -> FETCH.
  - JAL: RegWrite=1, WBSel=10, PCWrite=1, PCSrc=01. Retire, -> FETCH.
  - JALR: ALUOp=00, ALUSrcB=1, RegWrite=1, WBSel=10, PCWrite=1, PCSrc=10. Retire, -> FETCH.
  - LUI: RegWrite=1, WBSel=11. Retire, -> FETCH.
  - AUIPC: ALUSrcA=01, ALUSrcB=1, ALUOp=00, -> WB.
- MEM:
  - MemRead=1 (LOAD) or MemWrite=1 (STORE), held until MemReady.
  - LOAD -> WB. STORE: retire, -> FETCH.
- MULWAIT: hold until MulDivDone, then -> WB. MulDivStart is not re-pulsed.
- WB: RegWrite=1, WBSel=01 for LOAD else 00. Retire, -> FETCH.
- HALT: all strobes 0, Halt=1. Stays until reset; MemReady and MulDivDone are ignored.
- Retire:
  - InstRet increments on the clock edge of the retiring transition and wraps modulo 2^CNT_W.
  - Exactly one increment per valid instruction.
- Latency with MemReady=1 at entry:
  - BR, JAL, JALR, LUI: 3 cycles (FETCH-DECODE-EXEC).
  - STORE, R, I, AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- MemReady arriving outside FETCH/MEM is ignored. MulDivDone arriving outside MULWAIT is ignored.

Test Plan:
- Reset release, MemReady=1, then Opcode=0110011, Funct7_0=0 -> States 0,1,2,3,5,1. RegWrite=1 only in WB with WBSel=00. InstRet=1 after 5 cycles from reset release.
- LOAD with MemReady low for 3 cycles in MEM -> MemRead held 4 cycles, then WB with WBSel=01, InstRet +1. A STORE under the same stall holds MemWrite 4 cycles, never asserts RegWrite, and goes MEM -> FETCH.
- BR with BranchTaken=1, then BR with BranchTaken=0 -> first asserts PCWrite=1, PCSrc=01 in EXEC; second PCWrite=0. Both take 3 cycles and count.
- JALR -> EXEC asserts RegWrite=1, WBSel=10, PCWrite=1, PCSrc=10, ALUSrcB=1. LUI -> RegWrite=1, WBSel=11.
- Opcode=1111111 with ILLEGAL_HALT=1 -> State=7, Halt=1, InstRet unchanged, no strobes for 20 cycles. With ILLEGAL_HALT=0 -> DECODE -> FETCH, no count.
- MUL (Funct7_0=1, HAS_MULDIV=1), MulDivDone after 6 cycles, rst_n pulsed low mid-MULWAIT on a second run -> first run: MulDivStart pulses one cycle, then WB. Second run: State=0, InstRet=0 and all outputs 0 asynchronously. CNT_W=4 after 16 retires -> InstRet=0.
